itch_payload_assembler: RTL and testbench

Upstream framing stage for the per-type payload decoders, including the Delete Order decoder. It consumes a byte stream of length-prefixed ITCH messages: a 2-byte big-endian length followed by that many message bytes. It packs each message MSB-first into a 512-bit zero-padded payload and issues a one-cycle valid pulse, which is the payload/valid pair every decoder consumes.

---
 rtl/itch_payload_assembler.sv | 126 ++++++++++++
 tb/tb_itch_payload_assembler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/itch_payload_assembler.sv
// Frames a length-prefixed ITCH byte stream into MSB-first, zero-padded payloads.
// Each completed message is presented with a one-cycle valid pulse.
module itch_payload_assembler #(
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned LEN_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [7:0]             in_byte,
    output logic                   in_ready,
    output logic                   valid,
    output logic [8*MAX_BYTES-1:0] payload,
    output logic [LEN_W-1:0]       msg_len,
    output logic                   truncated,
    output logic [31:0]            msg_count
);

    localparam int unsigned PW    = 8 * MAX_BYTES;
    localparam int unsigned IDX_W = $clog2(MAX_BYTES);

    typedef enum logic [1:0] {StLenHi, StLenLo, StBody} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    buf_q, buf_d;
    logic             accept;
    logic             emit;
    logic             len_zero;
    logic             last_byte;
    logic             in_range;
    logic [LEN_W-1:0] cnt_inc;
    logic [IDX_W-1:0] slot;
    int unsigned      slot_base;

    assign accept    = in_valid && in_ready;
    assign len_zero  = ({len_q[LEN_W-1:8], in_byte} == '0);
    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign last_byte = (cnt_inc == len_q);
    assign in_range  = (cnt_q < LEN_W'(MAX_BYTES));
    assign slot      = cnt_q[IDX_W-1:0];
    // Byte k lands at the top of the payload: bits [PW-1-8k -: 8].
    assign slot_base = (MAX_BYTES - 1 - 32'(slot)) * 8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLenHi;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StLenHi;
        end else if (accept) begin
            unique case (state_q)
                StLenHi: state_d = StLenLo;
                StLenLo: state_d = len_zero ? StLenHi : StBody;
                StBody:  state_d = last_byte ? StLenHi : StBody;
                default: state_d = StLenHi;
            endcase
        end
    end

    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        buf_d = buf_q;
        emit  = 1'b0;
        if (flush) begin
            cnt_d = '0;
            buf_d = '0;
        end else if (accept) begin
            unique case (state_q)
                StLenHi: len_d[LEN_W-1 -: 8] = in_byte;
                StLenLo: begin
                    len_d[7:0] = in_byte;
                    if (!len_zero) begin
                        cnt_d = '0;
                        buf_d = '0;
                    end
                end
                StBody: begin
                    // Bytes beyond capacity are consumed but dropped to keep framing.
                    if (in_range) begin
                        buf_d[slot_base +: 8] = in_byte;
                    end
                    cnt_d = cnt_inc;
                    emit  = last_byte;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            in_ready  <= 1'b0;
            valid     <= 1'b0;
            payload   <= '0;
            msg_len   <= '0;
            truncated <= 1'b0;
            msg_count <= '0;
        end else begin
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            in_ready <= 1'b1;
            valid    <= emit;
            if (emit) begin
                payload   <= buf_d;
                msg_len   <= len_q;
                truncated <= (len_q > LEN_W'(MAX_BYTES));
                msg_count <= msg_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_itch_payload_assembler.sv
// Directed + randomized bench for itch_payload_assembler with a message-level reference model.
module tb_itch_payload_assembler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_byte = 8'h00;
    logic         in_ready;
    logic         valid;
    logic [511:0] payload;
    logic [15:0]  msg_len;
    logic         truncated;
    logic [31:0]  msg_count;

    itch_payload_assembler #(.MAX_BYTES(64), .LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .valid     (valid),
        .payload   (payload),
        .msg_len   (msg_len),
        .truncated (truncated),
        .msg_count (msg_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [511:0] p;
        logic [15:0]  len;
        logic         tr;
        logic [31:0]  cnt;
    } exp_t;

    int           cyc = 0;
    int           n_assert = 0;
    int           n_fail = 0;
    exp_t         q[$];
    exp_t         e;
    logic [511:0] m_payload = '0;
    logic [15:0]  m_len = '0;
    logic         m_trunc = 1'b0;
    logic [31:0]  m_count = '0;
    logic [7:0]   body[256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: every cycle out of reset, valid must match the scheduled emissions.
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("valid_pulse", {511'd0, valid}, 512'd1);
                chk("payload", payload, e.p);
                chk("msg_len", {496'd0, msg_len}, {496'd0, e.len});
                chk("truncated", {511'd0, truncated}, {511'd0, e.tr});
                chk("msg_count", {480'd0, msg_count}, {480'd0, e.cnt});
            end else begin
                chk("valid_idle", {511'd0, valid}, 512'd0);
            end
        end
    end

    task automatic put(input logic [7:0] b, input int pct);
        int nb = 0;
        @(posedge clk); #1;
        while (nb < 4 && int'($urandom_range(99)) < pct) begin
            in_valid = 1'b0;
            nb++;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_msg(input int len, input int pct);
        exp_t r;
        put(8'(len >> 8), pct);
        put(8'(len), pct);
        for (int k = 0; k < len; k++) put(body[k], pct);
        if (len > 0) begin
            m_payload = '0;
            for (int k = 0; k < len && k < 64; k++) m_payload[511-8*k -: 8] = body[k];
            m_len   = 16'(len);
            m_trunc = (len > 64);
            m_count = m_count + 1;
            r.due = cyc + 1;
            r.p   = m_payload;
            r.len = m_len;
            r.tr  = m_trunc;
            r.cnt = m_count;
            q.push_back(r);
        end
    endtask

    task automatic load_d();
        body[0] = 8'h44;
        for (int k = 1; k <= 8; k++) body[k] = 8'(k);
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_valid", {511'd0, valid}, 512'd0);
        chk("rst_payload", payload, 512'd0);
        chk("rst_len", {496'd0, msg_len}, 512'd0);
        chk("rst_count", {480'd0, msg_count}, 512'd0);
        chk("rst_ready", {511'd0, in_ready}, 512'd0);
        #10 rst = 1'b0;
        #1 chk("ready_before_edge", {511'd0, in_ready}, 512'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", {511'd0, in_ready}, 512'd1);

        // Single 'D' message
        load_d();
        send_msg(9, 0);
        idle(3);
        chk("d_top_byte", {504'd0, payload[511:504]}, {504'd0, 8'h44});
        chk("d_body", {448'd0, payload[503:440]}, {448'd0, 64'h0102030405060708});

        // Back-to-back, no bubbles
        send_msg(9, 0);
        body[0] = 8'h41; body[1] = 8'h42; body[2] = 8'h43;
        send_msg(3, 0);
        idle(3);

        // Bubbles everywhere
        load_d();
        send_msg(9, 40);
        idle(3);

        // Empty message then 'D'
        send_msg(0, 0);
        send_msg(9, 0);
        idle(3);

        // Truncation then a normal message
        for (int k = 0; k < 70; k++) body[k] = 8'(k);
        send_msg(70, 20);
        load_d();
        send_msg(9, 0);
        idle(3);

        // Reset mid-message
        put(8'h00, 0); put(8'h09, 0);
        for (int k = 0; k < 5; k++) put(body[k], 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_payload", payload, 512'd0);
        chk("mid_rst_len", {496'd0, msg_len}, 512'd0);
        chk("mid_rst_trunc", {511'd0, truncated}, 512'd0);
        chk("mid_rst_count", {480'd0, msg_count}, 512'd0);
        chk("mid_rst_ready", {511'd0, in_ready}, 512'd0);
        m_payload = '0; m_len = '0; m_trunc = 1'b0; m_count = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", {511'd0, in_ready}, 512'd1);
        send_msg(9, 0);
        idle(3);

        // Flush mid-message with a zero byte presented in the flush cycle
        put(8'h00, 0); put(8'h09, 0);
        for (int k = 0; k < 5; k++) put(body[k], 0);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'h00;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_payload_held", payload, m_payload);
        chk("flush_len_held", {496'd0, msg_len}, {496'd0, m_len});
        chk("flush_count_held", {480'd0, msg_count}, {480'd0, m_count});
        send_msg(9, 0);
        // Flush right after the last byte: the pending pulse must still appear
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle(2);

        // Random messages
        for (int m = 0; m < 6; m++) begin
            int len;
            len = int'($urandom_range(80, 1));
            for (int k = 0; k < len; k++) body[k] = 8'($urandom);
            send_msg(len, 25);
        end
        idle(5);
        chk("all_emitted", 512'(q.size()), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
